tl_axi_completer: RTL

- Completer side of the TL/AXI bridge. Pops received 4DW MemRd request headers from the Rx NP header FIFO and issues one AXI4 INCR read burst per request as an AXI master.
- Returns the read data as CplD TLPs. The 3DW completion header goes to the Tx Cpl header FIFO and the payload goes to the Tx Cpl data FIFO.
- Requests are split into multiple completions at MAX_PAYLOAD_SIZE. One request is in flight at a time.

---
 rtl/pcie_pkg.sv | 70 +++++++
 rtl/tl_axi_completer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pcie_pkg.sv
// PCIe TLP header layouts, completer constants and FSM encoding shared by the TL/AXI bridge.
// Address DWs of a request header are stored byte-reversed, the same order the Tx packer emits.
package pcie_pkg;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [4:0]  tlp_type;
    logic        tg_h;
    logic [2:0]  tc;
    logic        tg_m;
    logic        attr_h;
    logic        ln;
    logic        th;
    logic        td;
    logic        ep;
    logic [1:0]  attr;
    logic [1:0]  at;
    logic [9:0]  length;
    logic [15:0] requester_id;
    logic [7:0]  tag;
    logic [3:0]  last_be;
    logic [3:0]  first_be;
    logic [31:0] addr_h;
    logic [5:0]  addr_l;
    logic [1:0]  ph;
    logic [23:0] addr_m;
  } tlp_memory_req_hdr_t;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [4:0]  tlp_type;
    logic        tg_h;
    logic [2:0]  tc;
    logic        tg_m;
    logic        attr_h;
    logic        ln;
    logic        th;
    logic        td;
    logic        ep;
    logic [1:0]  attr;
    logic [1:0]  at;
    logic [9:0]  length;
    logic [15:0] completer_id;
    logic [2:0]  status;
    logic        bcm;
    logic [11:0] byte_count;
    logic [15:0] requester_id;
    logic [7:0]  tag;
    logic        rsvd;
    logic [6:0]  lower_addr;
  } tlp_cpl_hdr_t;

  localparam logic [2:0] FMT_4DW_NODATA = 3'b001;
  localparam logic [2:0] FMT_3DW_DATA   = 3'b010;
  localparam logic [4:0] TYPE_MEM       = 5'b00000;
  localparam logic [4:0] TYPE_CPL       = 5'b01010;
  localparam logic [2:0] CPL_STATUS_SC  = 3'b000;

  typedef enum logic [1:0] {IDLE, AR, DATA, HDR} cpl_fsm_t;

  function automatic logic [31:0] bswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // Bits [1:0] of the rebuilt address are forced to zero (the ph field sits there on the wire).
  function automatic logic [63:0] req_addr(input tlp_memory_req_hdr_t h);
    return {bswap32(h.addr_h), bswap32({h.addr_l, 2'b00, h.addr_m})};
  endfunction

endpackage

// File: rtl/tl_axi_completer.sv
// MemRd completer: pops one 4DW MemRd, issues one AXI INCR burst, returns CplD chunks of at most
// MAX_PAYLOAD_SIZE; each chunk's payload is written before its header. One request in flight.
module tl_axi_completer
  import pcie_pkg::*;
#(
  parameter int AXI_ID_WIDTH      = 4,
  parameter int AXI_ADDR_WIDTH    = 64,
  parameter int MAX_READ_REQ_SIZE = 512,
  parameter int MAX_PAYLOAD_SIZE  = 128
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [15:0]               config_bdf_i,
  input  logic                      rx_np_hdr_empty_i,
  input  logic [127:0]              rx_np_hdr_rdata_i,
  output logic                      rx_np_hdr_rden_o,
  output logic                      m_arvalid_o,
  input  logic                      m_arready_i,
  output logic [AXI_ID_WIDTH-1:0]   m_arid_o,
  output logic [AXI_ADDR_WIDTH-1:0] m_araddr_o,
  output logic [7:0]                m_arlen_o,
  output logic [2:0]                m_arsize_o,
  output logic [1:0]                m_arburst_o,
  input  logic                      m_rvalid_i,
  output logic                      m_rready_o,
  input  logic [255:0]              m_rdata_i,
  input  logic [1:0]                m_rresp_i,
  input  logic                      m_rlast_i,
  input  logic                      cpl_hdr_full_i,
  output logic                      cpl_hdr_wren_o,
  output logic [95:0]               cpl_hdr_wdata_o,
  input  logic                      cpl_data_full_i,
  output logic                      cpl_data_wren_o,
  output logic [255:0]              cpl_data_wdata_o,
  output logic                      err_unsupported_o,
  output logic                      busy_o
);

  localparam int          MPS_BEATS = MAX_PAYLOAD_SIZE / 32;
  localparam logic [7:0]  MPS_B     = 8'(MPS_BEATS);
  localparam logic [12:0] MRRS_B    = 13'(MAX_READ_REQ_SIZE);

  tlp_memory_req_hdr_t req;
  tlp_cpl_hdr_t        cpl;
  logic [63:0]         req_addr64;
  logic [10:0]         req_len_dw;
  logic [12:0]         req_bytes;
  logic                req_ok;

  cpl_fsm_t                  state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]                total_beats_q, total_beats_d;
  logic [15:0]               req_id_q, req_id_d;
  logic [9:0]                tag_q, tag_d;
  logic [7:0]                beat_cnt_q, beat_cnt_d;
  logic [7:0]                chunk_beats_q, chunk_beats_d;
  logic                      chunk_ep_q, chunk_ep_d;
  logic [12:0]               sent_q, sent_d;

  // rlast is not used for sequencing; the beat count derived from the request length is.
  logic unused_in;
  assign unused_in = ^{rx_np_hdr_rdata_i, m_rlast_i};

  assign req        = rx_np_hdr_rdata_i;
  assign req_addr64 = req_addr(req);
  assign req_len_dw = {(req.length == 10'd0), req.length};
  assign req_bytes  = {req_len_dw, 2'b00};
  assign req_ok     = (req.fmt == FMT_4DW_NODATA) && (req.tlp_type == TYPE_MEM) &&
                      (req_len_dw[2:0] == 3'd0) && (req_bytes <= MRRS_B) &&
                      (req_addr64[4:0] == 5'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      total_beats_q <= '0;
      req_id_q      <= '0;
      tag_q         <= '0;
      beat_cnt_q    <= '0;
      chunk_beats_q <= '0;
      chunk_ep_q    <= 1'b0;
      sent_q        <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      total_beats_q <= total_beats_d;
      req_id_q      <= req_id_d;
      tag_q         <= tag_d;
      beat_cnt_q    <= beat_cnt_d;
      chunk_beats_q <= chunk_beats_d;
      chunk_ep_q    <= chunk_ep_d;
      sent_q        <= sent_d;
    end
  end

  // Handshake outputs are held low while rst_n is low so an abandoned burst never writes.
  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    total_beats_d     = total_beats_q;
    req_id_d          = req_id_q;
    tag_d             = tag_q;
    beat_cnt_d        = beat_cnt_q;
    chunk_beats_d     = chunk_beats_q;
    chunk_ep_d        = chunk_ep_q;
    sent_d            = sent_q;
    rx_np_hdr_rden_o  = 1'b0;
    err_unsupported_o = 1'b0;
    m_arvalid_o       = 1'b0;
    m_rready_o        = 1'b0;
    cpl_data_wren_o   = 1'b0;
    cpl_hdr_wren_o    = 1'b0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (!rx_np_hdr_empty_i) begin
            rx_np_hdr_rden_o = 1'b1;
            if (req_ok) begin
              addr_d        = req_addr64[AXI_ADDR_WIDTH-1:0];
              total_beats_d = req_len_dw[10:3];
              req_id_d      = req.requester_id;
              tag_d         = {req.tg_h, req.tg_m, req.tag};
              state_d       = AR;
            end else begin
              err_unsupported_o = 1'b1;
            end
          end
        end
        AR: begin
          m_arvalid_o = 1'b1;
          if (m_arready_i) begin
            beat_cnt_d    = '0;
            chunk_beats_d = '0;
            chunk_ep_d    = 1'b0;
            sent_d        = '0;
            state_d       = DATA;
          end
        end
        DATA: begin
          m_rready_o      = !cpl_data_full_i;
          cpl_data_wren_o = m_rvalid_i && !cpl_data_full_i;
          if (cpl_data_wren_o) begin
            beat_cnt_d    = beat_cnt_q + 8'd1;
            chunk_beats_d = chunk_beats_q + 8'd1;
            chunk_ep_d    = chunk_ep_q | (m_rresp_i != 2'b00);
            if ((chunk_beats_d == MPS_B) || (beat_cnt_d == total_beats_q)) begin
              state_d = HDR;
            end
          end
        end
        HDR: begin
          if (!cpl_hdr_full_i) begin
            cpl_hdr_wren_o = 1'b1;
            sent_d         = sent_q + {chunk_beats_q, 5'b00000};
            chunk_beats_d  = '0;
            chunk_ep_d     = 1'b0;
            state_d        = (beat_cnt_q == total_beats_q) ? IDLE : DATA;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // byte_count keeps only 12 bits, so a remaining 4096 bytes encodes as 0.
  always_comb begin
    cpl              = '0;
    cpl.fmt          = FMT_3DW_DATA;
    cpl.tlp_type     = TYPE_CPL;
    cpl.tg_h         = tag_q[9];
    cpl.tg_m         = tag_q[8];
    cpl.ep           = chunk_ep_q;
    cpl.length       = 10'({chunk_beats_q, 3'b000});
    cpl.completer_id = config_bdf_i;
    cpl.status       = CPL_STATUS_SC;
    cpl.byte_count   = 12'({total_beats_q, 5'b00000} - sent_q);
    cpl.requester_id = req_id_q;
    cpl.tag          = tag_q[7:0];
    cpl.lower_addr   = addr_q[6:0] + sent_q[6:0];
  end

  assign cpl_hdr_wdata_o  = (rst_n && state_q == HDR) ? cpl : '0;
  assign cpl_data_wdata_o = (rst_n && state_q == DATA) ? m_rdata_i : '0;
  assign m_araddr_o       = (rst_n && state_q == AR) ? addr_q : '0;
  assign m_arlen_o        = (rst_n && state_q == AR) ? (total_beats_q - 8'd1) : '0;
  assign m_arid_o         = '0;
  assign m_arsize_o       = 3'd5;
  assign m_arburst_o      = 2'b01;
  assign busy_o           = (state_q != IDLE);

endmodule
